// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the SRAM slave.
package ahb_pkg;

  localparam int unsigned HADDR_SIZE_DEF = 32;
  localparam int unsigned HDATA_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SizeByte = 3'd0,
    SizeHalf = 3'd1,
    SizeWord = 3'd2
  } hsize_e;

  localparam logic RespOkay  = 1'b0;
  localparam logic RespError = 1'b1;

  typedef enum logic [1:0] {
    StOkay = 2'd0,
    StErr1 = 2'd1,
    StErr2 = 2'd2
  } err_state_e;

  // Byte lanes touched by a legal transfer at the given word offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [2:0] size);
    logic [3:0] mask;
    case (size)
      3'd0:    mask = 4'b0001 << off;
      3'd1:    mask = 4'b0011 << off;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/modport_mem.sv
// Word-wide SRAM: one byte-enabled write port and one registered read port.
module modport_mem #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = 32,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [Width/8-1:0]   i_be,
  input  logic [Aw-1:0]        i_waddr,
  input  logic [Width-1:0]     i_wdata,
  input  logic                 i_re,
  input  logic [Aw-1:0]        i_raddr,
  output logic [Width-1:0]     o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < int'(Width / 8); i++) begin
      if (i_we && i_be[i]) begin
        r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/modport_slave.sv
// AHB-Lite SRAM slave: zero-wait OKAY for legal transfers, two-cycle ERROR otherwise.
module modport_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_SIZE   = 4,
  parameter int unsigned HADDR_SIZE = HADDR_SIZE_DEF,
  parameter int unsigned HDATA_SIZE = HDATA_SIZE_DEF
) (
  input  logic                  i_hclk,
  input  logic                  i_hresetn,
  input  logic [HADDR_SIZE-1:0] i_haddr,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [2:0]            i_hburst,
  input  logic [3:0]            i_hprot,
  input  logic                  i_hmasterlock,
  input  logic [HDATA_SIZE-1:0] i_hwdata,
  output logic [HDATA_SIZE-1:0] o_hrdata,
  output logic                  o_hreadyout,
  output logic                  o_hready,
  output logic                  o_hresp
);

  localparam int unsigned Depth = MEM_SIZE * 256;
  localparam int unsigned Aw    = $clog2(Depth);
  localparam int unsigned Lanes = HDATA_SIZE / 8;
  localparam logic [HADDR_SIZE-1:0] MemBytes = HADDR_SIZE'(MEM_SIZE * 1024);

  err_state_e r_state;
  err_state_e w_state_next;

  logic            r_dp_valid;
  logic            r_dp_write;
  logic [Aw-1:0]   r_dp_waddr;
  logic [Lanes-1:0] r_dp_be;
  logic [Lanes-1:0] r_fwd_be;
  logic [HDATA_SIZE-1:0] r_fwd_data;

  logic            w_hready;
  logic            w_active;
  logic            w_accept;
  logic            w_legal;
  logic            w_align_ok;
  logic            w_bad;
  logic            w_rd_ok;
  logic            w_hazard;
  logic            w_we;
  logic [Aw-1:0]   w_raddr;
  logic [HDATA_SIZE-1:0] w_mem_rdata;
  logic            w_unused_ok;

  assign w_unused_ok = ^{i_hburst, i_hprot, i_hmasterlock};

  assign w_active   = (i_htrans == TransNonseq) || (i_htrans == TransSeq);
  assign w_accept   = w_hready && w_active;
  assign w_align_ok = (i_hsize == SizeHalf) ? !i_haddr[0] :
                      (i_hsize == SizeWord) ? (i_haddr[1:0] == 2'b00) : 1'b1;
  assign w_legal    = (i_haddr < MemBytes) && (i_hsize <= 3'd2) && w_align_ok;
  assign w_bad      = w_accept && !w_legal;
  assign w_rd_ok    = w_accept && w_legal && !i_hwrite;
  assign w_raddr    = i_haddr[Aw+1:2];

  // A read of the word being written this cycle sees the old array value; patch it later.
  assign w_hazard = r_dp_valid && r_dp_write && (r_dp_waddr == w_raddr);
  assign w_we     = i_hresetn && r_dp_valid && r_dp_write;

  always_ff @(posedge i_hclk) begin
    if (!i_hresetn) begin
      r_state <= StOkay;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = StOkay;
    unique case (r_state)
      StOkay, StErr2: w_state_next = w_bad ? StErr1 : StOkay;
      StErr1:         w_state_next = StErr2;
      default:        w_state_next = StOkay;
    endcase
  end

  always_comb begin
    w_hready    = (r_state != StErr1);
    o_hreadyout = w_hready;
    o_hready    = w_hready;
    o_hresp     = (r_state == StOkay) ? RespOkay : RespError;
  end

  always_ff @(posedge i_hclk) begin
    if (!i_hresetn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_waddr <= '0;
      r_dp_be    <= '0;
      r_fwd_be   <= '0;
      r_fwd_data <= '0;
    end else begin
      r_dp_valid <= w_accept && w_legal;
      if (w_accept) begin
        r_dp_write <= i_hwrite;
        r_dp_waddr <= w_raddr;
        r_dp_be    <= lane_mask(i_haddr[1:0], i_hsize);
      end
      if (w_rd_ok) begin
        r_fwd_be   <= w_hazard ? r_dp_be : '0;
        r_fwd_data <= i_hwdata;
      end
    end
  end

  modport_mem #(
    .Depth (Depth),
    .Width (HDATA_SIZE)
  ) u_mem (
    .i_clk   (i_hclk),
    .i_rst_n (i_hresetn),
    .i_we    (w_we),
    .i_be    (r_dp_be),
    .i_waddr (r_dp_waddr),
    .i_wdata (i_hwdata),
    .i_re    (w_rd_ok),
    .i_raddr (w_raddr),
    .o_rdata (w_mem_rdata)
  );

  always_comb begin
    o_hrdata = w_mem_rdata;
    for (int i = 0; i < int'(Lanes); i++) begin
      if (r_fwd_be[i]) begin
        o_hrdata[8*i +: 8] = r_fwd_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_modport_slave.sv
// Directed bench for modport_slave with a queue-based scoreboard and byte-level memory model.
module tb_modport_slave;

  logic        clk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmasterlock;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hready;
  logic        hresp;

  always #5 clk = ~clk;

  modport_slave #(
    .MEM_SIZE   (4),
    .HADDR_SIZE (32),
    .HDATA_SIZE (32)
  ) dut (
    .i_hclk        (clk),
    .i_hresetn     (hresetn),
    .i_haddr       (haddr),
    .i_htrans      (htrans),
    .i_hwrite      (hwrite),
    .i_hsize       (hsize),
    .i_hburst      (hburst),
    .i_hprot       (hprot),
    .i_hmasterlock (hmasterlock),
    .i_hwdata      (hwdata),
    .o_hrdata      (hrdata),
    .o_hreadyout   (hreadyout),
    .o_hready      (hready),
    .o_hresp       (hresp)
  );

  typedef struct {
    string       tag;
    logic        ready;
    logic        resp;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mm [int unsigned];
  logic [31:0] last_rd;
  logic [31:0] next_wdata;
  bit          skip_push;
  int          n_checks = 0;
  int          n_errors = 0;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, " hreadyout"}, {31'd0, hreadyout}, {31'd0, e.ready});
      chk({e.tag, " hready"}, {31'd0, hready}, {31'd0, e.ready});
      chk({e.tag, " hresp"}, {31'd0, hresp}, {31'd0, e.resp});
      chk({e.tag, " hrdata"}, hrdata, e.data);
    end
  endtask

  // One bus cycle: address phase of this transfer, data phase of the previous one.
  task automatic issue(input string tag, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata);
    exp_t e[$];
    bit legal;
    logic [31:0] cur;
    int unsigned word;
    haddr  = addr;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    hwdata = next_wdata;
    next_wdata = 32'h0;
    if (skip_push) begin
      skip_push = 1'b0;
    end else if (trans == NSEQ || trans == SEQ) begin
      legal = (addr < 32'h1000) && (size <= 3'd2) &&
              !(size == 3'd1 && addr[0]) && !(size == 3'd2 && addr[1:0] != 2'b00);
      if (!legal) begin
        e.push_back('{tag: {tag, " err1"}, ready: 1'b0, resp: 1'b1, data: last_rd});
        e.push_back('{tag: {tag, " err2"}, ready: 1'b1, resp: 1'b1, data: last_rd});
        skip_push = 1'b1;
      end else begin
        word = addr >> 2;
        cur  = mm.exists(word) ? mm[word] : 32'h0;
        if (wr) begin
          for (int i = 0; i < (1 << size); i++) begin
            int unsigned l;
            l = int'(addr[1:0]) + i;
            cur[8*l +: 8] = wdata[8*l +: 8];
          end
          mm[word]   = cur;
          next_wdata = wdata;
        end else begin
          last_rd = cur;
        end
        e.push_back('{tag: tag, ready: 1'b1, resp: 1'b0, data: last_rd});
      end
    end else begin
      e.push_back('{tag: tag, ready: 1'b1, resp: 1'b0, data: last_rd});
    end
    @(negedge clk);
    check_front();
    foreach (e[i]) sb.push_back(e[i]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    hresetn = 1'b0; haddr = '0; htrans = IDLE; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; hprot = 4'h3; hmasterlock = 1'b0; hwdata = '0;
    last_rd = 32'h0; next_wdata = 32'h0; skip_push = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("reset hresp", {31'd0, hresp}, 32'd0);
    chk("reset hrdata", hrdata, 32'h0);
    @(posedge clk);
    #1;
    hresetn = 1'b1;

    issue("w10",   NSEQ, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    issue("idle1", IDLE, 1'b0, 32'h0,  3'd2, 32'h0);
    issue("r10",   NSEQ, 1'b0, 32'h10, 3'd2, 32'h0);
    issue("idle2", IDLE, 1'b0, 32'h0,  3'd2, 32'h0);

    issue("w20",   NSEQ, 1'b1, 32'h20, 3'd2, 32'h0);
    issue("wb21",  NSEQ, 1'b1, 32'h21, 3'd0, 32'h0000AB00);
    issue("wh22",  SEQ,  1'b1, 32'h22, 3'd1, 32'h12340000);
    issue("idle3", IDLE, 1'b0, 32'h0,  3'd2, 32'h0);
    issue("r20",   NSEQ, 1'b0, 32'h20, 3'd2, 32'h0);
    issue("busy",  BUSY, 1'b0, 32'h0,  3'd2, 32'h0);

    issue("rbig",  NSEQ, 1'b0, 32'h1000, 3'd2, 32'h0);
    issue("ign",   NSEQ, 1'b1, 32'h10,   3'd2, 32'h11111111);
    issue("idle4", IDLE, 1'b0, 32'h0,    3'd2, 32'h0);
    issue("rmis",  NSEQ, 1'b0, 32'h02,   3'd2, 32'h0);
    issue("idle5", IDLE, 1'b0, 32'h0,    3'd2, 32'h0);
    issue("rsz3",  NSEQ, 1'b0, 32'h40,   3'd3, 32'h0);
    issue("idle6", IDLE, 1'b0, 32'h0,    3'd2, 32'h0);
    issue("whmis", NSEQ, 1'b1, 32'h41,   3'd1, 32'h0);
    issue("idle7", IDLE, 1'b0, 32'h0,    3'd2, 32'h0);

    issue("w30",   NSEQ, 1'b1, 32'h30, 3'd2, 32'hCAFEF00D);
    issue("r30",   NSEQ, 1'b0, 32'h30, 3'd2, 32'h0);
    issue("idle8", IDLE, 1'b0, 32'h0,  3'd2, 32'h0);
    issue("idle9", IDLE, 1'b0, 32'h0,  3'd2, 32'h0);
    issue("wb31",  NSEQ, 1'b1, 32'h31, 3'd0, 32'h00005500);
    issue("r30b",  NSEQ, 1'b0, 32'h30, 3'd2, 32'h0);
    issue("r10b",  NSEQ, 1'b0, 32'h10, 3'd2, 32'h0);
    issue("r20b",  SEQ,  1'b0, 32'h20, 3'd2, 32'h0);
    issue("idle10", IDLE, 1'b0, 32'h0, 3'd2, 32'h0);

    // Reset asserted while the slave is in the first error cycle.
    issue("rstbad", NSEQ, 1'b0, 32'h2000, 3'd2, 32'h0);
    hresetn = 1'b0;
    htrans  = IDLE;
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
    hresetn = 1'b1;
    sb.delete();
    skip_push  = 1'b0;
    next_wdata = 32'h0;
    last_rd    = 32'h0;
    @(negedge clk);
    chk("midrst hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("midrst hresp", {31'd0, hresp}, 32'd0);
    chk("midrst hrdata", hrdata, 32'h0);
    @(posedge clk);
    #1;

    issue("r30c",   NSEQ, 1'b0, 32'h30, 3'd2, 32'h0);
    issue("idle11", IDLE, 1'b0, 32'h0,  3'd2, 32'h0);
    issue("idle12", IDLE, 1'b0, 32'h0,  3'd2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
